// File: rtl/uart_periph_if.sv
// Register channel bundle between uart_periph and ucore_main.
// Carries the one-hot read/write selects, their acks, the data buses
// and the receive interrupt.
interface uart_periph_if;
   logic [3:0] uart_rcen;
   logic       uart_rack;
   logic [7:0] uart_rdata;
   logic [3:0] uart_wcen;
   logic       uart_wack;
   logic [7:0] uart_wdata;
   logic       uart_interrupt;

   modport master (
      output uart_rcen,
      output uart_wcen,
      output uart_wdata,
      input  uart_rack,
      input  uart_rdata,
      input  uart_wack,
      input  uart_interrupt
   );

   modport slave (
      input  uart_rcen,
      input  uart_wcen,
      input  uart_wdata,
      output uart_rack,
      output uart_rdata,
      output uart_wack,
      output uart_interrupt
   );
endinterface

// File: rtl/uart_periph.sv
// Byte-wide UART peripheral with a four-register one-hot read/write port.
// Registers: 0 RX (ro), 1 TX, 2 STATUS {0,0,0,0,ferr,tx_busy,ovr,rx_valid},
// 3 CTRL {0..0,rx_enable,rx_irq_en}.
//
// RX FSM
//   state    | meaning
//   RX_IDLE  | waiting for falling edge on synchronised rxd while enabled
//   RX_START | counting to mid start bit; line high there means glitch
//   RX_DATA  | sampling 8 data bits LSB first, one per bit period
//   RX_STOP  | sampling stop bit, then load/overrun/frame-error decision
//
// TX FSM
//   state    | meaning
//   TX_IDLE  | line idle high, tx_busy low
//   TX_START | driving start bit
//   TX_DATA  | driving 8 data bits LSB first from the TX register
//   TX_STOP  | driving stop bit; tx_busy drops when this period ends
module uart_periph #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic         clk,
   input  logic         areset,
   input  logic         uart_rxd,
   output logic         uart_txd,
   uart_periph_if.slave bus
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

   // synchroniser and edge detect
   logic rxd_meta_q, rxd_sync_q, rxd_prev_q;
   logic rx_fall;

   // receive FSM
   rx_state_t   rx_state_q, rx_state_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]  rx_bit_q, rx_bit_d;
   logic [7:0]  rx_shift_q, rx_shift_d;
   logic        rx_done_ok, rx_done_bad;

   // transmit FSM
   tx_state_t   tx_state_q, tx_state_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]  tx_bit_q, tx_bit_d;
   logic        txd_q, txd_d;
   logic        tx_busy;
   logic        tx_start;

   // register file
   logic [7:0]  rx_q, rx_d;
   logic [7:0]  tx_q, tx_d;
   logic        rx_valid_q, rx_valid_d;
   logic        ovr_q, ovr_d;
   logic        ferr_q, ferr_d;
   logic [1:0]  ctrl_q, ctrl_d;
   logic [7:0]  status;

   // handshake
   logic        rack_q, rack_d;
   logic        wack_q, wack_d;
   logic [7:0]  rdata_q, rdata_d;
   logic        irq_q, irq_d;
   logic        rd_acc, wr_acc;
   logic        rd_rx;
   logic        wr_tx, wr_st, wr_ctrl;
   logic        rx_load;

   assign rx_fall = rxd_prev_q & ~rxd_sync_q;
   assign tx_busy = (tx_state_q != TX_IDLE);
   assign status  = {4'b0000, ferr_q, tx_busy, ovr_q, rx_valid_q};

   assign uart_txd           = txd_q;
   assign bus.uart_rack      = rack_q;
   assign bus.uart_wack      = wack_q;
   assign bus.uart_rdata     = rdata_q;
   assign bus.uart_interrupt = irq_q;

   // two-flop synchroniser on the asynchronous rx line, plus one history flop
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         rxd_meta_q <= 1'b1;
         rxd_sync_q <= 1'b1;
         rxd_prev_q <= 1'b1;
      end else begin
         rxd_meta_q <= uart_rxd;
         rxd_sync_q <= rxd_meta_q;
         rxd_prev_q <= rxd_sync_q;
      end
   end

   // receive FSM state register
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
      end
   end

   // receive FSM next state; rx_enable only gates the start of a new frame
   always_comb begin
      rx_state_d  = rx_state_q;
      rx_cnt_d    = rx_cnt_q;
      rx_bit_d    = rx_bit_q;
      rx_shift_d  = rx_shift_q;
      rx_done_ok  = 1'b0;
      rx_done_bad = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            if (rx_fall && ctrl_q[1]) begin
               rx_state_d = RX_START;
               rx_cnt_d   = HALF_LAST;
            end
         end
         RX_START: begin
            if (rx_cnt_q == '0) begin
               if (rxd_sync_q) begin
                  rx_state_d = RX_IDLE;
               end else begin
                  rx_state_d = RX_DATA;
                  rx_cnt_d   = BIT_LAST;
                  rx_bit_d   = '0;
               end
            end else begin
               rx_cnt_d = rx_cnt_q - CNT_ONE;
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == '0) begin
               rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
               rx_cnt_d   = BIT_LAST;
               if (rx_bit_q == 3'd7) begin
                  rx_state_d = RX_STOP;
               end else begin
                  rx_bit_d = rx_bit_q + 3'd1;
               end
            end else begin
               rx_cnt_d = rx_cnt_q - CNT_ONE;
            end
         end
         RX_STOP: begin
            if (rx_cnt_q == '0) begin
               rx_state_d  = RX_IDLE;
               rx_done_ok  = rxd_sync_q;
               rx_done_bad = ~rxd_sync_q;
            end else begin
               rx_cnt_d = rx_cnt_q - CNT_ONE;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // transmit FSM state register; reset forces the line idle at once
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         txd_q      <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         txd_q      <= txd_d;
      end
   end

   // transmit FSM next state; the line is registered so each bit lasts a full period
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      txd_d      = txd_q;
      case (tx_state_q)
         TX_IDLE: begin
            txd_d = 1'b1;
            if (tx_start) begin
               tx_state_d = TX_START;
               tx_cnt_d   = BIT_LAST;
               txd_d      = 1'b0;
            end
         end
         TX_START: begin
            if (tx_cnt_q == '0) begin
               tx_state_d = TX_DATA;
               tx_cnt_d   = BIT_LAST;
               tx_bit_d   = '0;
               txd_d      = tx_q[0];
            end else begin
               tx_cnt_d = tx_cnt_q - CNT_ONE;
            end
         end
         TX_DATA: begin
            if (tx_cnt_q == '0) begin
               tx_cnt_d = BIT_LAST;
               if (tx_bit_q == 3'd7) begin
                  tx_state_d = TX_STOP;
                  txd_d      = 1'b1;
               end else begin
                  tx_bit_d = tx_bit_q + 3'd1;
                  txd_d    = tx_q[tx_bit_q + 3'd1];
               end
            end else begin
               tx_cnt_d = tx_cnt_q - CNT_ONE;
            end
         end
         TX_STOP: begin
            if (tx_cnt_q == '0) begin
               tx_state_d = TX_IDLE;
            end else begin
               tx_cnt_d = tx_cnt_q - CNT_ONE;
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   // read channel: accept when no ack is pending, lowest select bit wins
   always_comb begin
      rd_acc  = (bus.uart_rcen != 4'b0000) && !rack_q;
      rack_d  = rd_acc;
      rdata_d = rdata_q;
      rd_rx   = 1'b0;
      if (rd_acc) begin
         if (bus.uart_rcen[0]) begin
            rdata_d = rx_q;
            rd_rx   = 1'b1;
         end else if (bus.uart_rcen[1]) begin
            rdata_d = tx_q;
         end else if (bus.uart_rcen[2]) begin
            rdata_d = status;
         end else begin
            rdata_d = {6'b000000, ctrl_q};
         end
      end
   end

   // write channel decode; an RX write is acked but selects nothing
   always_comb begin
      wr_acc  = (bus.uart_wcen != 4'b0000) && !wack_q;
      wack_d  = wr_acc;
      wr_tx   = 1'b0;
      wr_st   = 1'b0;
      wr_ctrl = 1'b0;
      if (wr_acc && !bus.uart_wcen[0]) begin
         if (bus.uart_wcen[1]) begin
            wr_tx = 1'b1;
         end else if (bus.uart_wcen[2]) begin
            wr_st = 1'b1;
         end else begin
            wr_ctrl = 1'b1;
         end
      end
      tx_start = wr_tx && !tx_busy;
   end

   // register updates; a same-cycle RX read frees the slot for the new byte,
   // and hardware sets beat write-1-to-clear
   always_comb begin
      rx_load    = rx_done_ok && (!rx_valid_q || rd_rx);
      rx_d       = rx_load ? rx_shift_q : rx_q;
      tx_d       = tx_start ? bus.uart_wdata : tx_q;
      ctrl_d     = wr_ctrl ? bus.uart_wdata[1:0] : ctrl_q;
      rx_valid_d = rx_valid_q;
      if (rx_load) begin
         rx_valid_d = 1'b1;
      end else if (rd_rx) begin
         rx_valid_d = 1'b0;
      end
      ovr_d  = (ovr_q & ~(wr_st & bus.uart_wdata[1]))
             | (rx_done_ok & rx_valid_q & ~rd_rx);
      ferr_d = (ferr_q & ~(wr_st & bus.uart_wdata[3])) | rx_done_bad;
      irq_d  = rx_load & ctrl_q[0];
   end

   // register file, acks, read data and interrupt flops
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         rx_q       <= 8'h00;
         tx_q       <= 8'h00;
         rx_valid_q <= 1'b0;
         ovr_q      <= 1'b0;
         ferr_q     <= 1'b0;
         ctrl_q     <= 2'b11;
         rack_q     <= 1'b0;
         wack_q     <= 1'b0;
         rdata_q    <= 8'h00;
         irq_q      <= 1'b0;
      end else begin
         rx_q       <= rx_d;
         tx_q       <= tx_d;
         rx_valid_q <= rx_valid_d;
         ovr_q      <= ovr_d;
         ferr_q     <= ferr_d;
         ctrl_q     <= ctrl_d;
         rack_q     <= rack_d;
         wack_q     <= wack_d;
         rdata_q    <= rdata_d;
         irq_q      <= irq_d;
      end
   end

endmodule
